// File: rtl/mul_pkg.sv
// Shared defaults and FSM state type for the product accumulator slice.
package mul_pkg;

    localparam int unsigned PROD_W_DEF = 32;
    localparam int unsigned ACC_W_DEF  = 40;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / frame-result-out valid/ready bundle for product_accumulator.
interface product_accumulator_if
    import mul_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/product_accumulator_acc_sat_add.sv
// Accumulator adder: ACC_W+1 wide sum with carry out.
// Build option PRODUCT_ACCUMULATOR_SAT_EN clamps the result to all-ones on carry.
module acc_sat_add
    import mul_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide;

    always_comb begin
        wide  = {1'b0, acc} + (ACC_W+1)'(prod);
        carry = wide[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        sum   = carry ? '1 : wide[ACC_W-1:0];
`else
        sum   = wide[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator behind the 16x16 multiplier: sums products up to in_last and
// holds {sum, count, ovf} on a valid/ready output. Saturation via PRODUCT_ACCUMULATOR_SAT_EN.
module product_accumulator
    import mul_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    product_accumulator_if.slave bus
);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               first_beat;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   acc_sum;
    logic               carry;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_d = bus.in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready depends on state only, so in_valid never loops back into it.
    always_comb begin
        bus.in_ready  = (state_q != ST_HOLD);
        bus.out_valid = (state_q == ST_HOLD);
        accept        = bus.in_valid && (state_q != ST_HOLD);
        first_beat    = (state_q == ST_IDLE);
    end

    // The first beat of a frame adds onto zero, so its carry is always clear.
    always_comb begin
        acc_base = first_beat ? '0 : acc_q;
    end

    acc_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc   (acc_base),
        .prod  (bus.in_prod),
        .sum   (acc_sum),
        .carry (carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_sum;
            ovf_q <= (first_beat ? 1'b0 : ovf_q) | carry;
            if (first_beat) begin
                count_q <= CNT_W'(1);
            end else if (count_q != '1) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.out_sum   = acc_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives a 40-bit and a 33-bit accumulator with identical stimulus and checks
// each frame result against an arithmetic frame model.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        in_last;
    logic        out_ready;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] frame_q[$];

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) bus_a ();
    product_accumulator_if #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_prod   = in_prod;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_prod   = in_prod;
    assign bus_b.in_last   = in_last;
    assign bus_b.out_ready = out_ready;

    product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    product_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame result from plain arithmetic over the whole frame.
    function automatic void frame_model(input int unsigned acc_w, output logic [63:0] sum,
                                        output logic [63:0] cnt, output logic ovf);
        logic [63:0] total;
        logic [63:0] lim;
        total = 64'd0;
        foreach (frame_q[i]) total += 64'(frame_q[i]);
        lim = (64'd1 << acc_w) - 64'd1;
        ovf = (total > lim);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        sum = ovf ? lim : total;
`else
        sum = total & lim;
`endif
        cnt = (frame_q.size() > 255) ? 64'd255 : 64'(frame_q.size());
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_prod  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_state();
        check_eq("rst_valid_a", 64'(bus_a.out_valid), 64'd0);
        check_eq("rst_sum_a",   64'(bus_a.out_sum),   64'd0);
        check_eq("rst_count_a", 64'(bus_a.out_count), 64'd0);
        check_eq("rst_ovf_a",   64'(bus_a.out_ovf),   64'd0);
        check_eq("rst_ready_a", 64'(bus_a.in_ready),  64'd1);
        check_eq("rst_valid_b", 64'(bus_b.out_valid), 64'd0);
        check_eq("rst_sum_b",   64'(bus_b.out_sum),   64'd0);
    endtask

    task automatic check_result(input string tag);
        logic [63:0] sa, ca, sb, cb;
        logic        oa, ob;
        frame_model(40, sa, ca, oa);
        frame_model(33, sb, cb, ob);
        check_eq({tag, "_sum_a"},   64'(bus_a.out_sum),   sa);
        check_eq({tag, "_count_a"}, 64'(bus_a.out_count), ca);
        check_eq({tag, "_ovf_a"},   64'(bus_a.out_ovf),   64'(oa));
        check_eq({tag, "_sum_b"},   64'(bus_b.out_sum),   sb);
        check_eq({tag, "_count_b"}, 64'(bus_b.out_count), cb);
        check_eq({tag, "_ovf_b"},   64'(bus_b.out_ovf),   64'(ob));
    endtask

    // Sends frame_q; with last=0 the frame is left open and no result is expected.
    task automatic send_frame(input string tag, input int unsigned hold_cycles,
                              input bit gaps, input bit last);
        int unsigned t;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    idle_inputs();
                    step();
                end
            end
            in_valid = 1'b1;
            in_prod  = frame_q[i];
            in_last  = last && (i == frame_q.size() - 1);
            t = 0;
            while (!bus_a.in_ready && t < 20) begin
                step();
                t++;
            end
            if (!bus_a.in_ready) check_eq({tag, "_accept_timeout"}, 64'(bus_a.in_ready), 64'd1);
            if (i == frame_q.size() - 1) check_eq({tag, "_valid_early"}, 64'(bus_a.out_valid), 64'd0);
            step();
        end
        idle_inputs();
        if (!last) begin
            check_eq({tag, "_open_valid"}, 64'(bus_a.out_valid), 64'd0);
            return;
        end
        check_eq({tag, "_valid_lat_a"}, 64'(bus_a.out_valid), 64'd1);
        check_eq({tag, "_valid_lat_b"}, 64'(bus_b.out_valid), 64'd1);
        check_eq({tag, "_hold_ready"},  64'(bus_a.in_ready),  64'd0);
        check_result(tag);
        out_ready = 1'b0;
        for (int c = 0; c < int'(hold_cycles); c++) begin
            in_valid = 1'b1;
            in_prod  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            step();
            check_eq({tag, "_bp_valid"}, 64'(bus_a.out_valid), 64'd1);
            check_eq({tag, "_bp_ready"}, 64'(bus_a.in_ready),  64'd0);
            check_result({tag, "_bp"});
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_prod   = $urandom;
        step();
        idle_inputs();
        check_eq({tag, "_done_valid"}, 64'(bus_a.out_valid), 64'd0);
        check_eq({tag, "_done_ready"}, 64'(bus_a.in_ready),  64'd1);
        out_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        step();
        step();
        check_reset_state();
        rst_n = 1'b1;
        step();
        check_eq("post_rst_ready", 64'(bus_a.in_ready), 64'd1);

        frame_q = '{32'd9, 32'd3, 32'd120, 32'd75};
        send_frame("basic", 0, 1'b0, 1'b1);

        frame_q = '{32'd9173160};
        send_frame("single", 2, 1'b0, 1'b1);

        frame_q = '{32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001};
        send_frame("ovf33", 0, 1'b0, 1'b1);

        frame_q = '{32'd11, 32'd22, 32'd33};
        send_frame("bp", 3, 1'b0, 1'b1);
        frame_q = '{32'd7, 32'd8};
        send_frame("after_bp", 0, 1'b0, 1'b1);

        frame_q = '{32'd100, 32'd200};
        send_frame("abort", 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        check_reset_state();
        rst_n = 1'b1;
        frame_q = '{32'd5};
        send_frame("post_abort", 0, 1'b0, 1'b1);

        frame_q.delete();
        for (int i = 0; i < 260; i++) frame_q.push_back(32'd1);
        send_frame("cnt_sat", 1, 1'b0, 1'b1);

        frame_q.delete();
        for (int i = 0; i < 300; i++) frame_q.push_back(32'hFFFF_FFFF);
        send_frame("ovf40", 0, 1'b0, 1'b1);

        for (int f = 0; f < 25; f++) begin
            frame_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
                frame_q.push_back(32'($urandom_range(0, 65535)) * 32'($urandom_range(0, 65535)));
            end
            send_frame("rand", $urandom_range(0, 3), 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
